// File: rtl/rob_pkg.sv
// Shared types and helpers for the reorder buffer: slot record and tag/slot mapping.
// Tag 0 is reserved as "no broadcast", so tag = slot index + 1.
package rob_pkg;

  localparam int ROB_TAG_W  = 8;
  localparam int ROB_DATA_W = 32;

  localparam logic [ROB_TAG_W-1:0] TAG_NONE = '0;

  typedef struct packed {
    logic                  busy;
    logic                  done;
    logic                  is_store;
    logic [4:0]            rd;
    logic [ROB_DATA_W-1:0] data;
    logic [ROB_DATA_W-1:0] addr;
  } slot_t;

  function automatic logic [ROB_TAG_W-1:0] slot_to_tag(input logic [ROB_TAG_W-1:0] slot);
    return slot + 1'b1;
  endfunction

  function automatic logic [ROB_TAG_W-1:0] tag_to_slot(input logic [ROB_TAG_W-1:0] tag);
    return tag - 1'b1;
  endfunction

endpackage

// File: rtl/rob_ptr.sv
// Modulo-DEPTH wrapping pointer with synchronous clear; used for head and tail.
module rob_ptr #(
  parameter int DEPTH = 8,
  parameter int W     = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] ptr_o
);

  logic [W-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (clr_i) begin
      ptr_d = '0;
    end else if (inc_i) begin
      ptr_d = (ptr_q == W'(DEPTH - 1)) ? '0 : ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/reorder_buffer.sv
// In-order retirement buffer: allocates tagged slots, captures CDB results,
// retires completed slots in program order one per cycle; br flushes everything.
module reorder_buffer
  import rob_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int TAG_W  = ROB_TAG_W,
  parameter int DATA_W = ROB_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              br,
  input  logic              alloc_valid,
  input  logic [4:0]        alloc_rd,
  input  logic              alloc_is_store,
  output logic              alloc_ready,
  output logic [TAG_W-1:0]  alloc_tag,
  input  logic [TAG_W-1:0]  cdb_index,
  input  logic [DATA_W-1:0] cdb_data,
  input  logic [DATA_W-1:0] cdb_addr,
  input  logic [TAG_W-1:0]  q1_tag,
  input  logic [TAG_W-1:0]  q2_tag,
  output logic              q1_ready,
  output logic              q2_ready,
  output logic [DATA_W-1:0] q1_data,
  output logic [DATA_W-1:0] q2_data,
  output logic              commit_valid,
  output logic [TAG_W-1:0]  commit_tag,
  output logic [4:0]        commit_rd,
  output logic [DATA_W-1:0] commit_data,
  output logic [DATA_W-1:0] commit_addr,
  output logic              commit_is_store,
  output logic [TAG_W-1:0]  count,
  output logic              empty,
  output logic              full
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PTR_W-1:0]  head, tail;
  slot_t             slots_q [DEPTH];
  slot_t             slots_d [DEPTH];
  logic [TAG_W-1:0]  count_q;
  logic              commit_valid_q;
  logic [TAG_W-1:0]  commit_tag_q;
  logic [4:0]        commit_rd_q;
  logic [DATA_W-1:0] commit_data_q;
  logic [DATA_W-1:0] commit_addr_q;
  logic              commit_is_store_q;

  logic              alloc_fire;
  logic              retire;
  logic              cdb_in_range;
  logic              cdb_wr;
  logic [PTR_W-1:0]  cdb_slot;

  assign full        = (count_q == TAG_W'(DEPTH));
  assign empty       = (count_q == '0);
  assign alloc_ready = !full;
  assign alloc_fire  = alloc_valid && !full;
  assign alloc_tag   = TAG_W'(slot_to_tag(ROB_TAG_W'(tail)));
  assign retire      = slots_q[head].busy && slots_q[head].done;

  // Out-of-range tags are rejected before the slot lookup is trusted.
  assign cdb_in_range = (cdb_index != TAG_NONE) && (cdb_index <= TAG_W'(DEPTH));
  assign cdb_slot     = PTR_W'(tag_to_slot(ROB_TAG_W'(cdb_index)));
  assign cdb_wr       = cdb_in_range && slots_q[cdb_slot].busy && !slots_q[cdb_slot].done;

  rob_ptr #(.DEPTH(DEPTH), .W(PTR_W)) u_head (
    .clk   (clk),
    .rst   (rst),
    .clr_i (br),
    .inc_i (retire),
    .ptr_o (head)
  );

  rob_ptr #(.DEPTH(DEPTH), .W(PTR_W)) u_tail (
    .clk   (clk),
    .rst   (rst),
    .clr_i (br),
    .inc_i (alloc_fire),
    .ptr_o (tail)
  );

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      slots_d[i] = slots_q[i];
    end
    if (retire) begin
      slots_d[head].busy = 1'b0;
      slots_d[head].done = 1'b0;
    end
    if (cdb_wr) begin
      slots_d[cdb_slot].done = 1'b1;
      slots_d[cdb_slot].data = cdb_data;
      slots_d[cdb_slot].addr = cdb_addr;
    end
    if (alloc_fire) begin
      slots_d[tail].busy     = 1'b1;
      slots_d[tail].done     = 1'b0;
      slots_d[tail].is_store = alloc_is_store;
      slots_d[tail].rd       = alloc_rd;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (rst) begin
        slots_q[i] <= '0;
      end else if (br) begin
        slots_q[i].busy <= 1'b0;
        slots_q[i].done <= 1'b0;
      end else begin
        slots_q[i] <= slots_d[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q           <= '0;
      commit_valid_q    <= 1'b0;
      commit_tag_q      <= '0;
      commit_rd_q       <= '0;
      commit_data_q     <= '0;
      commit_addr_q     <= '0;
      commit_is_store_q <= 1'b0;
    end else if (br) begin
      count_q        <= '0;
      commit_valid_q <= 1'b0;
    end else begin
      count_q        <= count_q + TAG_W'(alloc_fire) - TAG_W'(retire);
      commit_valid_q <= retire;
      // Payload only moves on a retire so it holds the last committed value.
      if (retire) begin
        commit_tag_q      <= TAG_W'(slot_to_tag(ROB_TAG_W'(head)));
        commit_rd_q       <= slots_q[head].rd;
        commit_data_q     <= slots_q[head].data;
        commit_addr_q     <= slots_q[head].addr;
        commit_is_store_q <= slots_q[head].is_store;
      end
    end
  end

  assign count           = count_q;
  assign commit_valid    = commit_valid_q;
  assign commit_tag      = commit_tag_q;
  assign commit_rd       = commit_rd_q;
  assign commit_data     = commit_data_q;
  assign commit_addr     = commit_addr_q;
  assign commit_is_store = commit_is_store_q;

  logic [TAG_W-1:0]  q_tag [2];
  logic              q_rdy [2];
  logic [DATA_W-1:0] q_dat [2];

  assign q_tag[0] = q1_tag;
  assign q_tag[1] = q2_tag;

  for (genvar gi = 0; gi < 2; gi++) begin : g_query
    logic [PTR_W-1:0] qs;
    logic             q_live;
    logic             q_bypass;

    assign qs       = PTR_W'(tag_to_slot(ROB_TAG_W'(q_tag[gi])));
    assign q_live   = (q_tag[gi] != TAG_NONE) && (q_tag[gi] <= TAG_W'(DEPTH)) && slots_q[qs].busy;
    assign q_bypass = (cdb_index == q_tag[gi]);
    assign q_rdy[gi] = q_live && (q_bypass || slots_q[qs].done);
    assign q_dat[gi] = !q_live           ? '0 :
                       q_bypass          ? cdb_data :
                       slots_q[qs].done  ? slots_q[qs].data : '0;
  end

  assign q1_ready = q_rdy[0];
  assign q2_ready = q_rdy[1];
  assign q1_data  = q_dat[0];
  assign q2_data  = q_dat[1];

endmodule

// File: tb/tb_reorder_buffer.sv
// Randomized scoreboard bench for reorder_buffer against a program-order queue model.
module tb_reorder_buffer;

  localparam int DEPTH  = 8;
  localparam int TAG_W  = 8;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst, br;
  logic              alloc_valid, alloc_is_store, alloc_ready;
  logic [4:0]        alloc_rd;
  logic [TAG_W-1:0]  alloc_tag, cdb_index, q1_tag, q2_tag, commit_tag, count;
  logic [DATA_W-1:0] cdb_data, cdb_addr, q1_data, q2_data, commit_data, commit_addr;
  logic              q1_ready, q2_ready, commit_valid, commit_is_store, empty, full;
  logic [4:0]        commit_rd;

  reorder_buffer #(.DEPTH(DEPTH), .TAG_W(TAG_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .br(br),
    .alloc_valid(alloc_valid), .alloc_rd(alloc_rd), .alloc_is_store(alloc_is_store),
    .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
    .cdb_index(cdb_index), .cdb_data(cdb_data), .cdb_addr(cdb_addr),
    .q1_tag(q1_tag), .q2_tag(q2_tag), .q1_ready(q1_ready), .q2_ready(q2_ready),
    .q1_data(q1_data), .q2_data(q2_data),
    .commit_valid(commit_valid), .commit_tag(commit_tag), .commit_rd(commit_rd),
    .commit_data(commit_data), .commit_addr(commit_addr), .commit_is_store(commit_is_store),
    .count(count), .empty(empty), .full(full)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  tag;
    logic [4:0]  rd;
    logic        st;
    bit          done;
    logic [31:0] data;
    logic [31:0] addr;
  } ent_t;

  typedef struct {
    int          cyc;
    logic [7:0]  tag;
    logic [4:0]  rd;
    logic        st;
    logic [31:0] data;
    logic [31:0] addr;
  } exp_t;

  ent_t rob[$];
  exp_t expq[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   next_tag = 1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int find(input logic [7:0] tag);
    for (int i = 0; i < rob.size(); i++) if (rob[i].tag == tag) return i;
    return -1;
  endfunction

  task automatic qexp(input logic [7:0] t, input logic [7:0] ci, input logic [31:0] cd,
                      output logic rdy, output logic [31:0] d);
    int idx;
    idx = find(t);
    rdy = 1'b0;
    d   = '0;
    if (t != 0 && idx >= 0) begin
      if (ci == t) begin
        rdy = 1'b1; d = cd;
      end else if (rob[idx].done) begin
        rdy = 1'b1; d = rob[idx].data;
      end
    end
  endtask

  // One clock of stimulus: check registered status, drive, check comb outputs, advance model.
  task automatic step(input bit av, input logic [4:0] rd, input bit st,
                      input logic [7:0] ci, input logic [31:0] cd, input logic [31:0] ca,
                      input bit b, input logic [7:0] t1, input logic [7:0] t2);
    bit          rdy_exp;
    logic        er;
    logic [31:0] ed;
    int          idx;
    exp_t        e;
    @(negedge clk);
    chk("count", count, rob.size());
    chk("empty", empty, rob.size() == 0);
    chk("full", full, rob.size() == DEPTH);
    alloc_valid = av; alloc_rd = rd; alloc_is_store = st;
    cdb_index = ci; cdb_data = cd; cdb_addr = ca;
    br = b; q1_tag = t1; q2_tag = t2;
    #1;
    rdy_exp = rob.size() < DEPTH;
    chk("alloc_ready", alloc_ready, rdy_exp);
    chk("alloc_tag", alloc_tag, next_tag);
    qexp(t1, ci, cd, er, ed);
    chk("q1_ready", q1_ready, er);
    chk("q1_data", q1_data, ed);
    qexp(t2, ci, cd, er, ed);
    chk("q2_ready", q2_ready, er);
    chk("q2_data", q2_data, ed);
    if (b) begin
      rob.delete();
      next_tag = 1;
    end else begin
      if (rob.size() > 0 && rob[0].done) begin
        e.cyc = cyc + 1; e.tag = rob[0].tag; e.rd = rob[0].rd; e.st = rob[0].st;
        e.data = rob[0].data; e.addr = rob[0].addr;
        expq.push_back(e);
        void'(rob.pop_front());
      end
      if (ci != 0) begin
        idx = find(ci);
        if (idx >= 0 && !rob[idx].done) begin
          rob[idx].done = 1'b1; rob[idx].data = cd; rob[idx].addr = ca;
        end
      end
      if (av && rdy_exp) begin
        rob.push_back('{tag: 8'(next_tag), rd: rd, st: st, done: 1'b0, data: '0, addr: '0});
        next_tag = (next_tag == DEPTH) ? 1 : next_tag + 1;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Commit monitor: every pulse must match the oldest expected retire, on its cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (commit_valid) begin
        if (expq.size() == 0) begin
          chk("unexpected_commit", commit_tag, 0);
        end else begin
          exp_t e;
          e = expq.pop_front();
          chk("commit_cycle", cyc, e.cyc);
          chk("commit_tag", commit_tag, e.tag);
          chk("commit_rd", commit_rd, e.rd);
          chk("commit_is_store", commit_is_store, e.st);
          chk("commit_data", commit_data, e.data);
          if (e.st) chk("commit_addr", commit_addr, e.addr);
          $display("commit tag=%0d rd=%0d st=%0d data=%08h addr=%08h cycle=%0d",
                   commit_tag, commit_rd, commit_is_store, commit_data, commit_addr, cyc);
        end
      end else if (expq.size() > 0 && expq[0].cyc <= cyc) begin
        chk("missing_commit", 0, expq[0].tag);
        void'(expq.pop_front());
      end
    end
  end

  initial begin
    rst = 1; br = 0; alloc_valid = 0; alloc_rd = 0; alloc_is_store = 0;
    cdb_index = 0; cdb_data = 0; cdb_addr = 0; q1_tag = 0; q2_tag = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_commit_valid", commit_valid, 0);
    chk("rst_commit_tag", commit_tag, 0);
    chk("rst_commit_data", commit_data, 0);
    chk("rst_alloc_tag", alloc_tag, 1);
    rst = 0;

    // Fill to full, then a refused ninth alloc.
    for (int i = 1; i <= 8; i++) step(1, 5'(i), 0, 0, 0, 0, 0, 0, 0);
    step(1, 5'd9, 0, 0, 0, 0, 0, 1, 8);
    // Out-of-order completion, in-order retire; also out-of-range and tag-0 CDB.
    step(0, 0, 0, 8'd3, 32'hA5, 0, 0, 3, 0);
    step(0, 0, 0, 8'd200, 32'hDEAD, 0, 0, 3, 1);
    step(0, 0, 0, 8'd1, 32'h11, 0, 0, 1, 3);
    step(0, 0, 0, 8'd2, 32'h22, 0, 0, 2, 0);
    step(0, 0, 0, 8'd3, 32'hFF, 0, 0, 3, 0);
    idle(4);
    // Refill to full, complete head, alloc refused on the retire edge, then accepted.
    for (int i = 0; i < 3; i++) step(1, 5'(9 + i), 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 8'd4, 32'h44, 0, 0, 0, 0);
    step(1, 5'd20, 0, 0, 0, 0, 0, 4, 0);
    step(1, 5'd21, 0, 0, 0, 0, 0, 0, 0);
    idle(2);
    step(0, 0, 0, 0, 0, 0, 1, 0, 0);
    // Store retire with address.
    step(1, 5'd1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 5'd0, 1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 8'd2, 32'hBEEF, 32'h1000, 0, 2, 0);
    step(0, 0, 0, 8'd1, 32'h1, 0, 0, 2, 1);
    idle(4);
    // Five busy, bypass query on tag 5, then flush during a CDB write.
    step(0, 0, 0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 5; i++) step(1, 5'(i + 3), 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 8'd5, 32'h77, 0, 0, 5, 0);
    step(0, 0, 0, 8'd4, 32'h99, 0, 1, 4, 5);
    step(1, 5'd7, 0, 0, 0, 0, 0, 0, 0);
    idle(2);

    for (int n = 0; n < 2000; n++) begin
      logic [7:0] ci;
      int         r;
      r = int'($urandom % 10);
      if (r < 6 && rob.size() > 0) ci = rob[$urandom % rob.size()].tag;
      else if (r == 6) ci = 0;
      else if (r == 7) ci = 8'($urandom_range(DEPTH + 1, 255));
      else ci = 8'($urandom_range(1, DEPTH));
      step(($urandom % 3) != 0, 5'($urandom), 1'($urandom), ci, $urandom, $urandom,
           ($urandom % 40) == 0,
           (($urandom % 4) == 0) ? ci : 8'($urandom_range(0, DEPTH + 1)),
           8'($urandom_range(0, DEPTH)));
    end
    idle(4);
    chk("drain_expected_empty", expq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
